icache_fill_ctrl: RTL and testbench
===================================

// Module: icache_fill_ctrl
// PURPOSE
//   Direct-mapped instruction cache and read initiator in front of the word-wide instruction memory.
//   Serves CPU fetches on a hit with zero added latency.
//   On a miss, stalls the CPU, fetches the whole line from memory one word at a time over the
//   read/busywait handshake, installs the line, then serves the fetch.
//   Sits between the fetch stage and the instruction memory.
// PARAMETERS
//   ADDR_W        8   byte-address width; bits[1:0] are ignored (word aligned)
//   IDX_W         3   line-index width; 2**IDX_W lines
//   WORDS_PER_LN  4   32-bit words per line; fixed at 4 (word offset is addr[3:2])
//   Tag width TAG_W = ADDR_W-4-IDX_W (default 1); address layout = {tag, idx, word[1:0], byte[1:0]}
// PORTS
//   clock            in   1       rising-edge clock
//   reset            in   1       asynchronous, active-low reset
//   cpu_read         in   1       fetch request; address must stay stable while cpu_busywait=1
//   cpu_address      in   ADDR_W  fetch byte address
//   cpu_instruction  out  32      fetched word; valid when cpu_read=1 and cpu_busywait=0
//   cpu_busywait     out  1       stall to CPU
//   mem_read         out  1       read request to instruction memory
//   mem_address      out  ADDR_W  word-aligned byte address to memory
//   mem_readdata     in   32      memory data; valid in the cycle mem_busywait=0 with mem_read=1
//   mem_busywait     in   1       memory busy; low while mem_read=1 means word accepted this edge
// BEHAVIOUR
//   Reset (async, reset=0):
//     - all valid bits cleared; FSM to IDLE; word_cnt=0
//     - mem_read=0, mem_address=0, cpu_instruction=0, cpu_busywait=0
//     - tag/data arrays are not cleared
//   hit (combinational) = cpu_read & valid[idx] & (tag_arr[idx]==tag).
//   FSM states:
//     IDLE
//       - hit: cpu_busywait=0, cpu_instruction=data[idx][addr[3:2]]
//       - cpu_read & !hit: cpu_busywait=1 in the same cycle; latch {tag,idx}; word_cnt=0; next=MEM_READ
//       - cpu_read=0: cpu_busywait=0, cpu_instruction=0
//     MEM_READ
//       - mem_read=1, mem_address={ltag,lidx,word_cnt,2'b00}
//       - on an edge with mem_busywait=0: store mem_readdata into line buffer[word_cnt]
//       - if word_cnt==3, next=UPDATE; else word_cnt+1, next=MEM_GAP
//     MEM_GAP
//       - mem_read=0 for exactly 1 cycle (memory detects requests on read edges); next=MEM_READ
//     UPDATE
//       - write buffer to data[lidx], tag_arr[lidx]=ltag, valid[lidx]=1; next=IDLE
//       - hit is re-evaluated in IDLE on the following cycle
//   cpu_busywait=1 in MEM_READ, MEM_GAP and UPDATE regardless of cpu_read.
//   Miss penalty, with memory latency L cycles per word (busywait drops in the L-th cycle of mem_read):
//     - cpu_busywait high for 4L+5 cycles
//     - data valid in the following cycle
//   Boundary cases:
//     - cpu_read dropped mid-fill: fill completes and the line is installed; no abort
//     - cpu_address changed mid-fill: fill uses the latched address; the new address is checked in IDLE
//     - reset mid-fill: mem_read drops immediately; no partial line is marked valid
//     - miss to an occupied index overwrites that line (no write-back; instruction lines are read-only)
//     - mem_busywait=0 on the first MEM_READ cycle is legal (L=1)
// TESTING
//   1. Cold miss: reset, cpu_read=1, addr=8'h00, L=2
//      -> mem_address 00,04,08,0C in order; cpu_busywait high 13 cycles;
//         then cpu_instruction=mem[0x00]; valid[0]=1
//   2. Hit after fill: addr=8'h08 next cycle
//      -> cpu_busywait=0 the same cycle; cpu_instruction=mem[0x08]; mem_read stays 0
//   3. Conflict: fill 8'h00, then read 8'h80 (same idx, tag 1)
//      -> miss with a refill of 80..8C; a subsequent read of 8'h00 misses again
//   4. Handshake gap: L=1 -> mem_read pattern 1,0,1,0,1,0,1 across the fill; cpu_busywait high 9 cycles
//   5. Reset mid-fill: assert reset after word 1 accepted
//      -> mem_read=0 immediately; after release, addr 8'h00 misses again
//   6. cpu_read dropped mid-fill: line still installed; later read of the same line hits with no mem_read

Source files
------------

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a line-fill read initiator.
// Hits are served combinationally; misses stall the CPU while four words are fetched.
module icache_fill_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int IDX_W        = 3,
  parameter int WORDS_PER_LN = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_address,
  output logic [31:0]       cpu_instruction,
  output logic              cpu_busywait,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_busywait
);

  localparam int TAG_W  = ADDR_W - 4 - IDX_W;
  localparam int NLINES = 1 << IDX_W;
  localparam int WORD_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_READ,
    S_MEM_GAP,
    S_UPDATE
  } state_t;

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  ltag_q, ltag_d;
  logic [IDX_W-1:0]  lidx_q, lidx_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [NLINES-1:0] valid_q;

  logic [31:0]       line_buf_q [WORDS_PER_LN];
  logic [31:0]       data_arr_q [NLINES][WORDS_PER_LN];
  logic [TAG_W-1:0]  tag_arr_q  [NLINES];

  logic [TAG_W-1:0]  tag_s;
  logic [IDX_W-1:0]  idx_s;
  logic [WORD_W-1:0] word_s;
  logic              hit;
  logic              word_done;
  logic [1:0]        unused_byte_bits;

  assign tag_s            = cpu_address[ADDR_W-1 -: TAG_W];
  assign idx_s            = cpu_address[IDX_W+3:4];
  assign word_s           = cpu_address[3:2];
  assign unused_byte_bits = cpu_address[1:0];

  assign hit       = cpu_read & valid_q[idx_s] & (tag_arr_q[idx_s] == tag_s);
  assign word_done = (state_q == S_MEM_READ) & ~mem_busywait;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ltag_q  <= '0;
      lidx_q  <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ltag_q  <= ltag_d;
      lidx_q  <= lidx_d;
      cnt_q   <= cnt_d;
      if (state_q == S_UPDATE) begin
        valid_q[lidx_q] <= 1'b1;
      end
    end
  end

  // Tag/data arrays and the line buffer carry no reset; valid bits alone gate their use.
  always_ff @(posedge clock) begin
    if (word_done) begin
      line_buf_q[cnt_q] <= mem_readdata;
    end
    if (state_q == S_UPDATE) begin
      data_arr_q[lidx_q] <= line_buf_q;
      tag_arr_q[lidx_q]  <= ltag_q;
    end
  end

  always_comb begin
    state_d = state_q;
    ltag_d  = ltag_q;
    lidx_d  = lidx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_read && !hit) begin
          ltag_d  = tag_s;
          lidx_d  = idx_s;
          cnt_d   = '0;
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        if (!mem_busywait) begin
          if (cnt_q == WORD_W'(WORDS_PER_LN - 1)) begin
            state_d = S_UPDATE;
          end else begin
            cnt_d   = cnt_q + WORD_W'(1);
            state_d = S_MEM_GAP;
          end
        end
      end
      S_MEM_GAP: state_d = S_MEM_READ;
      S_UPDATE:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_busywait    = 1'b0;
    cpu_instruction = '0;
    mem_read        = 1'b0;
    mem_address     = '0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          cpu_instruction = data_arr_q[idx_s][word_s];
        end else if (cpu_read) begin
          cpu_busywait = 1'b1;
        end
      end
      S_MEM_READ: begin
        cpu_busywait = 1'b1;
        mem_read     = 1'b1;
        mem_address  = {ltag_q, lidx_q, cnt_q, 2'b00};
      end
      S_MEM_GAP: cpu_busywait = 1'b1;
      S_UPDATE:  cpu_busywait = 1'b1;
      default:   cpu_busywait = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl with a latency-programmable memory model
// and a line-level cache reference model.
module tb_icache_fill_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_read;
  logic [7:0]  cpu_address;
  logic [31:0] cpu_instruction;
  logic        cpu_busywait;
  logic        mem_read;
  logic [7:0]  mem_address;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int errors = 0;
  int checks = 0;
  int lat    = 2;
  int mcnt   = 0;

  logic [31:0] mem_arr [64];
  logic        ref_valid [8];
  logic        ref_tag   [8];
  logic [7:0]  acc_q [$];

  icache_fill_ctrl #(.ADDR_W(8), .IDX_W(3), .WORDS_PER_LN(4)) dut (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_address(cpu_address),
    .cpu_instruction(cpu_instruction), .cpu_busywait(cpu_busywait),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  // Memory: busywait drops in the lat-th cycle of a read request.
  assign mem_busywait = !(mem_read && (mcnt >= lat - 1));
  assign mem_readdata = mem_arr[mem_address[7:2]];

  always @(posedge clock) begin
    if (mem_read && !mem_busywait) begin
      acc_q.push_back(mem_address);
      mcnt <= 0;
    end else if (mem_read) begin
      mcnt <= mcnt + 1;
    end else begin
      mcnt <= 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_ref();
    foreach (ref_valid[i]) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 1'b0;
    end
  endtask

  // Reference: expected stall length, word, mem_read trace and accepted addresses.
  task automatic model(input logic [7:0] a, output int eb, output logic [31:0] ei,
                       output logic [63:0] ep, output logic [31:0] eacc, output int enacc);
    int unsigned idx;
    idx  = a[6:4];
    ei   = mem_arr[a[7:2]];
    ep   = '0;
    eacc = '0;
    if (ref_valid[idx] && (ref_tag[idx] == a[7])) begin
      eb    = 0;
      enacc = 0;
    end else begin
      eb    = 4 * lat + 5;
      enacc = 4;
      for (int k = 0; k < 4; k++) begin
        eacc = {eacc[23:0], {a[7:4], 4'h0} + 8'(4 * k)};
        for (int j = 0; j < lat; j++) ep = {ep[62:0], 1'b1};
        if (k < 3) ep = {ep[62:0], 1'b0};
      end
      ep = {ep[62:0], 1'b0};
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = a[7];
    end
    ep = {ep[62:0], 1'b0};
  endtask

  task automatic do_fetch(input logic [7:0] a, output int nb, output logic [31:0] ins,
                          output logic [63:0] pat, output logic [31:0] acc, output int nacc);
    @(negedge clock);
    acc_q.delete();
    cpu_read    = 1'b1;
    cpu_address = a;
    #1;
    nb  = 0;
    pat = '0;
    while (cpu_busywait && nb < 200) begin
      pat = {pat[62:0], mem_read};
      nb++;
      @(negedge clock);
      #1;
    end
    pat  = {pat[62:0], mem_read};
    ins  = cpu_instruction;
    acc  = '0;
    nacc = acc_q.size();
    foreach (acc_q[i]) if (i < 4) acc = {acc[23:0], acc_q[i]};
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_read = 1'b0; cpu_address = '0;
    clear_ref();
    repeat (2) @(negedge clock);
    #1;
    checks++; if (cpu_busywait !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", cpu_busywait); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b expected 0", mem_read); end
    checks++; if (mem_address !== 8'h00) begin errors++; $display("FAIL rst_mem_addr: got %h expected 00", mem_address); end
    checks++; if (cpu_instruction !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", cpu_instruction); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_cold_miss();
    int nb, nacc, eb, enacc; logic [31:0] ins, acc, ei, eacc; logic [63:0] pat, ep;
    lat = 2;
    model(8'h00, eb, ei, ep, eacc, enacc);
    do_fetch(8'h00, nb, ins, pat, acc, nacc);
    checks++; if (nb !== 13) begin errors++; $display("FAIL cold_busy: got %0d expected 13", nb); end
    checks++; if (acc !== 32'h0004080C) begin errors++; $display("FAIL cold_addrs: got %h expected 0004080c", acc); end
    checks++; if (ins !== mem_arr[0]) begin errors++; $display("FAIL cold_instr: got %h expected %h", ins, mem_arr[0]); end
    checks++; if (pat !== ep) begin errors++; $display("FAIL cold_trace: got %h expected %h", pat, ep); end
  endtask

  task automatic test_hit();
    int nb, nacc, eb, enacc; logic [31:0] ins, acc, ei, eacc; logic [63:0] pat, ep;
    model(8'h08, eb, ei, ep, eacc, enacc);
    do_fetch(8'h08, nb, ins, pat, acc, nacc);
    checks++; if (nb !== 0) begin errors++; $display("FAIL hit_busy: got %0d expected 0", nb); end
    checks++; if (ins !== mem_arr[2]) begin errors++; $display("FAIL hit_instr: got %h expected %h", ins, mem_arr[2]); end
    checks++; if (nacc !== 0 || pat !== 64'h0) begin errors++; $display("FAIL hit_no_mem: got %0d reads expected 0", nacc); end
  endtask

  task automatic test_conflict();
    int nb, nacc, eb, enacc; logic [31:0] ins, acc, ei, eacc; logic [63:0] pat, ep;
    model(8'h80, eb, ei, ep, eacc, enacc);
    do_fetch(8'h80, nb, ins, pat, acc, nacc);
    checks++; if (nb !== 13) begin errors++; $display("FAIL conf_busy: got %0d expected 13", nb); end
    checks++; if (acc !== 32'h8084888C) begin errors++; $display("FAIL conf_addrs: got %h expected 8084888c", acc); end
    checks++; if (ins !== mem_arr[32]) begin errors++; $display("FAIL conf_instr: got %h expected %h", ins, mem_arr[32]); end
    model(8'h00, eb, ei, ep, eacc, enacc);
    do_fetch(8'h00, nb, ins, pat, acc, nacc);
    checks++; if (nb !== 13) begin errors++; $display("FAIL conf_remiss: got %0d expected 13", nb); end
    checks++; if (acc !== 32'h0004080C) begin errors++; $display("FAIL conf_readdrs: got %h expected 0004080c", acc); end
  endtask

  task automatic test_gap();
    int nb, nacc, eb, enacc; logic [31:0] ins, acc, ei, eacc; logic [63:0] pat, ep;
    lat = 1;
    model(8'h34, eb, ei, ep, eacc, enacc);
    do_fetch(8'h34, nb, ins, pat, acc, nacc);
    checks++; if (nb !== 9) begin errors++; $display("FAIL gap_busy: got %0d expected 9", nb); end
    checks++; if (pat !== 64'h154) begin errors++; $display("FAIL gap_trace: got %h expected 154", pat); end
    checks++; if (acc !== 32'h3034383C) begin errors++; $display("FAIL gap_addrs: got %h expected 3034383c", acc); end
    checks++; if (ins !== mem_arr[13]) begin errors++; $display("FAIL gap_instr: got %h expected %h", ins, mem_arr[13]); end
  endtask

  task automatic test_reset_mid_fill();
    int nb, nacc, eb, enacc, waitc; logic [31:0] ins, acc, ei, eacc; logic [63:0] pat, ep;
    lat = 2;
    @(negedge clock);
    acc_q.delete();
    cpu_read = 1'b1; cpu_address = 8'h50;
    waitc = 0;
    while (acc_q.size() < 2 && waitc < 100) begin @(negedge clock); waitc++; end
    checks++; if (acc_q.size() < 2) begin errors++; $display("FAIL rmf_wait: got %0d words expected 2", acc_q.size()); end
    @(negedge clock); #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rmf_pre: got %b expected 1", mem_read); end
    reset = 1'b0; cpu_read = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rmf_mem_read: got %b expected 0", mem_read); end
    checks++; if (cpu_busywait !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b expected 0", cpu_busywait); end
    clear_ref();
    @(negedge clock);
    reset = 1'b1;
    model(8'h50, eb, ei, ep, eacc, enacc);
    do_fetch(8'h50, nb, ins, pat, acc, nacc);
    checks++; if (nb !== eb || acc !== eacc) begin errors++; $display("FAIL rmf_refill: got %0d/%h expected %0d/%h", nb, acc, eb, eacc); end
    checks++; if (ins !== ei) begin errors++; $display("FAIL rmf_instr: got %h expected %h", ins, ei); end
    model(8'h00, eb, ei, ep, eacc, enacc);
    do_fetch(8'h00, nb, ins, pat, acc, nacc);
    checks++; if (nb !== 13) begin errors++; $display("FAIL rmf_remiss: got %0d expected 13", nb); end
  endtask

  task automatic test_drop_read();
    int nb, nacc, eb, enacc, waitc; logic [31:0] ins, acc, ei, eacc; logic [63:0] pat, ep;
    lat = 3;
    model(8'h64, eb, ei, ep, eacc, enacc);
    @(negedge clock);
    acc_q.delete();
    cpu_read = 1'b1; cpu_address = 8'h64;
    repeat (3) @(negedge clock);
    cpu_read = 1'b0; cpu_address = 8'($urandom);
    #1;
    waitc = 0;
    while (cpu_busywait && waitc < 200) begin @(negedge clock); #1; waitc++; end
    checks++; if (cpu_busywait !== 1'b0) begin errors++; $display("FAIL drop_done: got %b expected 0", cpu_busywait); end
    acc = '0;
    foreach (acc_q[i]) if (i < 4) acc = {acc[23:0], acc_q[i]};
    checks++; if (acc_q.size() !== enacc || acc !== eacc) begin errors++; $display("FAIL drop_addrs: got %h expected %h", acc, eacc); end
    model(8'h68, eb, ei, ep, eacc, enacc);
    do_fetch(8'h68, nb, ins, pat, acc, nacc);
    checks++; if (nb !== 0 || nacc !== 0) begin errors++; $display("FAIL drop_hit: got %0d/%0d expected 0/0", nb, nacc); end
    checks++; if (ins !== mem_arr[26]) begin errors++; $display("FAIL drop_instr: got %h expected %h", ins, mem_arr[26]); end
  endtask

  task automatic test_random();
    int nb, nacc, eb, enacc; logic [31:0] ins, acc, ei, eacc; logic [63:0] pat, ep; logic [7:0] a;
    for (int n = 0; n < 40; n++) begin
      lat = $urandom_range(1, 4);
      a   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        cpu_read = 1'b0;
      end
      model(a, eb, ei, ep, eacc, enacc);
      do_fetch(a, nb, ins, pat, acc, nacc);
      checks++; if (nb !== eb) begin errors++; $display("FAIL rnd_busy[%0d] a=%h: got %0d expected %0d", n, a, nb, eb); end
      checks++; if (ins !== ei) begin errors++; $display("FAIL rnd_instr[%0d] a=%h: got %h expected %h", n, a, ins, ei); end
      checks++; if (pat !== ep) begin errors++; $display("FAIL rnd_trace[%0d] a=%h: got %h expected %h", n, a, pat, ep); end
      checks++; if (nacc !== enacc || acc !== eacc) begin errors++; $display("FAIL rnd_addrs[%0d] a=%h: got %h expected %h", n, a, acc, eacc); end
    end
  endtask

  initial begin
    foreach (mem_arr[i]) mem_arr[i] = $urandom;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_gap();
    test_reset_mid_fill();
    test_drop_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
